// File: rtl/genius_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : genius_pkg                                                |
// | Brief     : Shared state encoding, button codes and LFSR taps for the |
// |             Genius (Simon) game controller.                           |
// | Revision  : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
package genius_pkg;

  // Controller states; the encoding is visible on the STATE debug port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    SHOW  = 3'd2,
    INPUT = 3'd3,
    WIN   = 3'd4,
    LOSE  = 3'd5
  } state_t;

  // Button codes delivered by the debounced decoder.
  localparam logic [3:0] BTN_NONE       = 4'd0;
  localparam logic [3:0] BTN_POWER      = 4'd1;
  localparam logic [3:0] BTN_COLOR_BASE = 4'd2;

  // Galois feedback mask for taps 16,14,13,11 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/genius_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : genius_lfsr                                               |
// | Brief     : Free-running 16-bit Galois LFSR that also reduces its low |
// |             byte to a colour index in 0..NUM_COLORS-1.                |
// | Revision  : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
module genius_lfsr
  import genius_pkg::*;
#(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          NUM_COLORS = 4,
  localparam int         CW         = $clog2(NUM_COLORS)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [CW-1:0] color_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value: shift right, fold the outgoing bit back in via the taps.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // LFSR register; steps every cycle, reloads SEED on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign color_o = CW'(lfsr_q[7:0] % 8'(NUM_COLORS));

endmodule
`default_nettype wire

// File: rtl/genius_game_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : genius_game_fsm                                           |
// | Brief     : Genius (Simon) game controller. Grows a random colour     |
// |             sequence, plays it through the display timer handshake    |
// |             and checks the player's echo under an input timeout.      |
// | Revision  : 1.0 - initial parametrised release                        |
// +----------------------------------------------------------------------+
module genius_game_fsm
  import genius_pkg::*;
#(
  parameter int          NUM_COLORS = 4,
  parameter int          MAX_LEN    = 16,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         CW         = $clog2(NUM_COLORS),
  localparam int         LW         = $clog2(MAX_LEN + 1)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          R,
  input  logic [3:0]    B,
  input  logic [1:0]    C,
  input  logic          END_1,
  input  logic          END_2,
  output logic          START_1,
  output logic          START_2,
  output logic          VGA_FLAG,
  output logic [CW-1:0] VGA,
  output logic          VGA_WIN,
  output logic          VGA_LOSE,
  output logic [LW-1:0] LEVEL,
  output logic [2:0]    STATE
);

  localparam int IW = $clog2(MAX_LEN);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic          r_q;
  state_t        state_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] target_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] seq_q [MAX_LEN];
  logic          start1_q;
  logic          start2_q;
  logic          flag_q;
  logic [CW-1:0] vga_q;
  logic          win_q;
  logic          lose_q;

  // ---------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------
  logic          w_press;
  logic          w_power;
  logic          w_is_color;
  logic          w_color_press;
  logic [CW-1:0] w_press_color;
  logic [CW-1:0] w_lfsr_color;
  logic [LW-1:0] w_target;
  logic [IW-1:0] w_last_idx;
  logic [IW-1:0] w_idx_inc;
  logic [IW-1:0] w_wr_idx;
  logic          w_at_last;
  logic          w_match;

  genius_lfsr #(
    .SEED       (SEED),
    .NUM_COLORS (NUM_COLORS)
  ) u_lfsr (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .color_o (w_lfsr_color)
  );

  // A press is the rising edge of the button-valid level.
  assign w_press       = R & ~r_q;
  assign w_power       = w_press && (B == BTN_POWER);
  assign w_is_color    = (B != BTN_NONE) && (B >= BTN_COLOR_BASE) &&
                         ((B - BTN_COLOR_BASE) < 4'(NUM_COLORS));
  assign w_color_press = w_press && w_is_color;
  assign w_press_color = CW'(B - BTN_COLOR_BASE);

  // Difficulty maps to a quarter, half, three quarters or all of storage.
  assign w_target   = LW'((int'(C) + 1) * (MAX_LEN / 4));

  // len is at least 1 whenever idx is compared against the last position.
  assign w_last_idx = IW'(len_q - 1'b1);
  assign w_idx_inc  = IW'(idx_q + 1'b1);
  assign w_wr_idx   = IW'(len_q);
  assign w_at_last  = (idx_q == w_last_idx);
  assign w_match    = (w_press_color == seq_q[idx_q]);

  // Button level history for edge detection.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_q <= 1'b0;
    end else begin
      r_q <= R;
    end
  end

  // Sequence store: appended with a fresh random colour once per round.
  always_ff @(posedge CLK) begin
    if (state_q == GEN) begin
      seq_q[w_wr_idx] <= w_lfsr_color;
    end
  end

  // Game controller: state, counters and all registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      len_q    <= '0;
      target_q <= '0;
      idx_q    <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      flag_q   <= 1'b0;
      vga_q    <= '0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
    end else begin
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      if (w_power && (state_q != IDLE)) begin
        // POWER aborts any game in progress.
        state_q <= IDLE;
        len_q   <= '0;
        idx_q   <= '0;
        flag_q  <= 1'b0;
        vga_q   <= '0;
        win_q   <= 1'b0;
        lose_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (w_power) begin
              target_q <= w_target;
              len_q    <= '0;
              idx_q    <= '0;
              state_q  <= GEN;
            end
          end
          GEN: begin
            len_q    <= len_q + 1'b1;
            idx_q    <= '0;
            state_q  <= SHOW;
            start1_q <= 1'b1;
            flag_q   <= 1'b1;
            // On the first round entry 0 is being written this very edge.
            vga_q    <= (len_q == '0) ? w_lfsr_color : seq_q[0];
          end
          SHOW: begin
            if (END_1) begin
              if (w_at_last) begin
                idx_q    <= '0;
                state_q  <= INPUT;
                start2_q <= 1'b1;
                flag_q   <= 1'b0;
                vga_q    <= '0;
              end else begin
                idx_q    <= w_idx_inc;
                start1_q <= 1'b1;
                vga_q    <= seq_q[w_idx_inc];
              end
            end
          end
          INPUT: begin
            // A colour press takes precedence over a coincident timeout.
            if (w_color_press) begin
              if (w_match) begin
                if (w_at_last) begin
                  idx_q <= '0;
                  if (len_q == target_q) begin
                    state_q <= WIN;
                    win_q   <= 1'b1;
                  end else begin
                    state_q <= GEN;
                  end
                end else begin
                  idx_q    <= w_idx_inc;
                  start2_q <= 1'b1;
                end
              end else begin
                state_q <= LOSE;
                lose_q  <= 1'b1;
              end
            end else if (END_2) begin
              state_q <= LOSE;
              lose_q  <= 1'b1;
            end
          end
          WIN, LOSE: begin
            // Result is held until POWER or RESET.
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign START_1  = start1_q;
  assign START_2  = start2_q;
  assign VGA_FLAG = flag_q;
  assign VGA      = vga_q;
  assign VGA_WIN  = win_q;
  assign VGA_LOSE = lose_q;
  assign LEVEL    = len_q;
  assign STATE    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_genius_game_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_genius_game_fsm                                        |
// | Brief     : Directed self-checking bench for genius_game_fsm with     |
// |             default parameters (4 colours, depth 16, C=0 -> target 4).|
// | Revision  : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_genius_game_fsm;

  logic       CLK = 1'b0;
  logic       RESET, R, END_1, END_2;
  logic [3:0] B;
  logic [1:0] C;
  logic       START_1, START_2, VGA_FLAG, VGA_WIN, VGA_LOSE;
  logic [1:0] VGA;
  logic [4:0] LEVEL;
  logic [2:0] STATE;

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  exp_seq [16];

  genius_game_fsm dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .R        (R),
    .B        (B),
    .C        (C),
    .END_1    (END_1),
    .END_2    (END_2),
    .START_1  (START_1),
    .START_2  (START_2),
    .VGA_FLAG (VGA_FLAG),
    .VGA      (VGA),
    .VGA_WIN  (VGA_WIN),
    .VGA_LOSE (VGA_LOSE),
    .LEVEL    (LEVEL),
    .STATE    (STATE)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR: Galois, taps 16,14,13,11, seed ACE1, steps every edge.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic press(input logic [3:0] code);
    R = 1'b1; B = code;
    @(negedge CLK);
    R = 1'b0; B = 4'd0;
  endtask

  task automatic power_up();
    @(negedge CLK);
    press(4'd1);
  endtask

  // Plays one round starting in the GEN cycle.
  // mode: 0 normal, 1 wrong colour at 'at', 2 END_2 at 'at', 3 END_2 with
  // correct press at 'at', 4 hold R 4 cycles at 'at', 5 colour press during
  // SHOW at 'at', 6 stop on INPUT entry.
  task automatic play_round(input int n, input int mode, input int at);
    logic [3:0] good, bad;
    exp_seq[n-1] = 2'(m_lfsr[7:0] % 8'd4);
    n_vec++;
    if (STATE !== 3'd1) begin n_fail++; $display("FAIL gen_state r%0d got %0d want 1", n, STATE); end
    @(negedge CLK);
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if ({STATE, START_1, VGA_FLAG, VGA} !== {3'd2, 1'b1, 1'b1, exp_seq[i]}) begin
        n_fail++;
        $display("FAIL show_entry r%0d i%0d got st=%0d s1=%b fl=%b vga=%0d want st=2 s1=1 fl=1 vga=%0d",
                 n, i, STATE, START_1, VGA_FLAG, VGA, exp_seq[i]);
      end
      n_vec++;
      if (LEVEL !== 5'(n)) begin n_fail++; $display("FAIL show_level r%0d got %0d want %0d", n, LEVEL, n); end
      if (mode == 5 && i == at) begin
        press(4'd2 + 4'(2'(exp_seq[i] + 2'd1)));
        n_vec++;
        if ({STATE, VGA, START_1} !== {3'd2, exp_seq[i], 1'b0}) begin
          n_fail++;
          $display("FAIL show_press_ignored got st=%0d vga=%0d s1=%b want st=2 vga=%0d s1=0", STATE, VGA, START_1, exp_seq[i]);
        end
      end else begin
        @(negedge CLK);
        n_vec++;
        if ({START_1, VGA_FLAG} !== 2'b01) begin
          n_fail++; $display("FAIL show_pulse_width got s1=%b fl=%b want s1=0 fl=1", START_1, VGA_FLAG);
        end
      end
      END_1 = 1'b1;
      @(negedge CLK);
      END_1 = 1'b0;
    end
    n_vec++;
    if ({STATE, START_2, VGA_FLAG, VGA} !== {3'd3, 1'b1, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL input_entry r%0d got st=%0d s2=%b fl=%b vga=%0d want st=3 s2=1 fl=0 vga=0", n, STATE, START_2, VGA_FLAG, VGA);
    end
    if (mode == 6) return;
    for (int i = 0; i < n; i++) begin
      good = 4'd2 + 4'(exp_seq[i]);
      bad  = 4'd2 + 4'(2'(exp_seq[i] + 2'd1));
      if (mode == 1 && i == at) begin
        press(bad);
        n_vec++;
        if ({STATE, VGA_LOSE, VGA_FLAG} !== {3'd5, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL wrong_colour got st=%0d lose=%b fl=%b want st=5 lose=1 fl=0", STATE, VGA_LOSE, VGA_FLAG);
        end
        return;
      end
      if (mode == 2 && i == at) begin
        END_2 = 1'b1;
        @(negedge CLK);
        END_2 = 1'b0;
        n_vec++;
        if ({STATE, VGA_LOSE} !== {3'd5, 1'b1}) begin
          n_fail++; $display("FAIL timeout_lose got st=%0d lose=%b want st=5 lose=1", STATE, VGA_LOSE);
        end
        return;
      end
      if (mode == 3 && i == at) begin
        END_2 = 1'b1;
        press(good);
        END_2 = 1'b0;
        n_vec++;
        if ({STATE, START_2, VGA_LOSE} !== {3'd3, 1'b1, 1'b0}) begin
          n_fail++; $display("FAIL press_beats_timeout got st=%0d s2=%b lose=%b want st=3 s2=1 lose=0", STATE, START_2, VGA_LOSE);
        end
      end else if (mode == 4 && i == at) begin
        R = 1'b1; B = good;
        repeat (4) @(negedge CLK);
        R = 1'b0; B = 4'd0;
        n_vec++;
        if ({STATE, START_2} !== {3'd3, 1'b0}) begin
          n_fail++; $display("FAIL held_r_one_press got st=%0d s2=%b want st=3 s2=0", STATE, START_2);
        end
      end else begin
        press(good);
        if (i < n - 1) begin
          n_vec++;
          if ({STATE, START_2} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL correct_press r%0d i%0d got st=%0d s2=%b want st=3 s2=1", n, i, STATE, START_2);
          end
        end
      end
      if (i < n - 1) @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; R = 1'b0; B = 4'd0; C = 2'd0; END_1 = 1'b0; END_2 = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if ({START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", {START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE});
    end
    RESET = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (STATE !== 3'd0) begin n_fail++; $display("FAIL reset_idle_hold got %0d want 0", STATE); end
  endtask

  task automatic test_power_start();
    power_up();
    n_vec++;
    if ({STATE, LEVEL, START_1} !== {3'd1, 5'd0, 1'b0}) begin
      n_fail++; $display("FAIL power_to_gen got st=%0d lvl=%0d s1=%b want st=1 lvl=0 s1=0", STATE, LEVEL, START_1);
    end
    exp_seq[0] = 2'(m_lfsr[7:0] % 8'd4);
    @(negedge CLK);
    n_vec++;
    if ({START_1, VGA_FLAG, LEVEL, VGA} !== {1'b1, 1'b1, 5'd1, exp_seq[0]}) begin
      n_fail++;
      $display("FAIL first_show got s1=%b fl=%b lvl=%0d vga=%0d want s1=1 fl=1 lvl=1 vga=%0d", START_1, VGA_FLAG, LEVEL, VGA, exp_seq[0]);
    end
  endtask

  task automatic test_power_mid_show();
    press(4'd1);
    n_vec++;
    if ({START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE} !== 15'd0) begin
      n_fail++; $display("FAIL power_mid_show got %h want 0", {START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE});
    end
  endtask

  task automatic test_win();
    power_up();
    for (int n = 1; n <= 4; n++) play_round(n, 0, 0);
    n_vec++;
    if ({STATE, VGA_WIN, LEVEL, VGA_FLAG} !== {3'd4, 1'b1, 5'd4, 1'b0}) begin
      n_fail++; $display("FAIL win got st=%0d win=%b lvl=%0d fl=%b want st=4 win=1 lvl=4 fl=0", STATE, VGA_WIN, LEVEL, VGA_FLAG);
    end
    END_2 = 1'b1; @(negedge CLK); END_2 = 1'b0;
    END_1 = 1'b1; @(negedge CLK); END_1 = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if ({STATE, VGA_WIN, VGA_LOSE} !== {3'd4, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL win_hold got st=%0d win=%b lose=%b want st=4 win=1 lose=0", STATE, VGA_WIN, VGA_LOSE);
    end
    power_up();
    n_vec++;
    if ({START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE} !== 15'd0) begin
      n_fail++; $display("FAIL win_power_idle got %h want 0", {START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE});
    end
  endtask

  task automatic test_wrong_colour();
    power_up();
    play_round(1, 0, 0);
    play_round(2, 1, 1);
    power_up();
    n_vec++;
    if ({START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE} !== 15'd0) begin
      n_fail++; $display("FAIL lose_power_idle got %h want 0", {START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE});
    end
  endtask

  task automatic test_timeout();
    power_up();
    play_round(1, 0, 0);
    play_round(2, 2, 0);
    power_up();
  endtask

  task automatic test_back_to_back();
    power_up();
    play_round(1, 0, 0);
    play_round(2, 3, 0);
    play_round(3, 5, 1);
    play_round(4, 4, 0);
    n_vec++;
    if ({STATE, VGA_WIN, LEVEL} !== {3'd4, 1'b1, 5'd4}) begin
      n_fail++; $display("FAIL b2b_win got st=%0d win=%b lvl=%0d want st=4 win=1 lvl=4", STATE, VGA_WIN, LEVEL);
    end
    power_up();
  endtask

  task automatic test_async_reset();
    power_up();
    play_round(1, 6, 0);
    #2 RESET = 1'b1;
    #1;
    n_vec++;
    if ({START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE} !== 15'd0) begin
      n_fail++; $display("FAIL async_reset got %h want 0", {START_1, START_2, VGA_FLAG, VGA, VGA_WIN, VGA_LOSE, LEVEL, STATE});
    end
    #1 RESET = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (STATE !== 3'd0) begin n_fail++; $display("FAIL after_async_reset got %0d want 0", STATE); end
  endtask

  initial begin
    test_reset();
    test_power_start();
    test_power_mid_show();
    test_win();
    test_wrong_colour();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test sequence");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/genius_game_fsm.md
# genius_game_fsm

Parametrised Genius (Simon) game controller, successor to the fixed four-colour controller. Generates a pseudo-random colour sequence of configurable length. It plays the sequence through the display/sound timer handshake (START_1/END_1) and checks player input against it under a timeout handshake (START_2/END_2). It drives the VGA status flags for win and lose. It sits between the debounced button decoder and the VGA/timer blocks.

## Interface
- NUM_COLORS, 4, number of colour buttons; legal range 2..8
- MAX_LEN, 16, sequence storage depth; multiple of 4, at least 4
- SEED, 16'hACE1, LFSR reset value; must be nonzero
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- R  in  1  button-valid level; one press per rising edge of R
- B  in  4  button code: 0 none, 1 POWER, 2+k colour k (k < NUM_COLORS), others ignored
- C  in  2  difficulty, latched at game start; target length = (C+1)*MAX_LEN/4
- END_1  in  1  display timer done (1-cycle pulse)
- END_2  in  1  input timeout expired (1-cycle pulse)
- START_1  out  1  1-cycle pulse: start display timer
- START_2  out  1  1-cycle pulse: start/restart input timeout
- VGA_FLAG  out  1  high while a sequence colour is displayed
- VGA  out  clog2(NUM_COLORS)  colour index being displayed, 0 otherwise
- VGA_WIN  out  1  held high in WIN
- VGA_LOSE  out  1  held high in LOSE
- LEVEL  out  clog2(MAX_LEN+1)  current sequence length
- STATE  out  3  state encoding, debug

## Operation
- Press edge: r_q is R registered each cycle, and press = R & ~r_q. Holding R for multiple cycles gives one press.
- Priority: RESET > POWER press > END_2/colour press > other events.
- A POWER press in any non-IDLE state goes to IDLE next edge and clears LEVEL and the index.
- IDLE: all outputs 0. A POWER press latches target from C, sets len=0, and goes to GEN.
- GEN (1 cycle): seq[len] <= LFSR colour, len++, idx=0, then SHOW.
- LFSR colour is lfsr[7:0] % NUM_COLORS. The LFSR is 16-bit Galois with taps 16,14,13,11. It steps every cycle from reset.
- SHOW: START_1 pulses on the entry cycle. VGA=seq[idx] and VGA_FLAG=1 throughout.
  - On END_1 with idx==len-1: idx=0, go to INPUT.
  - On END_1 otherwise: idx++ and re-enter SHOW with a fresh START_1 pulse.
  - Colour presses here are consumed and ignored.
- INPUT: START_2 pulses on entry and on each accepted correct press. VGA_FLAG=0.
  - Correct press with idx<len-1: idx++.
  - Correct press with idx==len-1: go to WIN if len==target, else go to GEN.
  - Wrong colour: go to LOSE.
  - END_2: go to LOSE.
  - A colour press and END_2 in the same cycle: the press wins.
  - Invalid codes and B=0 are ignored.
- WIN / LOSE: the flag is held until a POWER press (goes to IDLE) or RESET.
- END_1 outside SHOW and END_2 outside INPUT are ignored.

## Timing
- RESET asserted: next state is IDLE immediately. All outputs are 0, LEVEL=0, lfsr=SEED, r_q=0, and seq contents are don't-care.
- All state changes take effect on the CLK edge that samples the triggering input. The outputs for the new state appear after that edge, so latency is 1 cycle.
- START_1 and START_2 are registered pulses, exactly 1 cycle wide, asserted in the first cycle of the state.
- POWER press to first START_1: 2 edges (IDLE to GEN to SHOW).
- LEVEL increments at GEN exit. LEVEL saturates structurally because target ≤ MAX_LEN.

## Structure
- Package genius_pkg holds:
  - state enum: IDLE, GEN, SHOW, INPUT, WIN, LOSE
  - button code constants: BTN_NONE=0, BTN_POWER=1, BTN_COLOR_BASE=2
  - LFSR tap constant
- One sub-module, genius_lfsr: 16-bit Galois LFSR with SEED parameter, stepping every cycle.
- The sequence store is a register array of MAX_LEN x clog2(NUM_COLORS) bits, written only in GEN.

## Test plan
- Reset then POWER press with C=0 (defaults): edge+1 STATE=GEN, edge+2 START_1=1, VGA_FLAG=1, LEVEL=1, and VGA matches the bench LFSR model.
- Defaults, C=0 (target 4): echo each round correctly with END_1/END_2 never firing. After the 4th correct press VGA_WIN=1, LEVEL=4, and it holds until POWER.
- Round 2, idx 1, wrong colour: next edge VGA_LOSE=1 and VGA_FLAG=0. A POWER press then gives all outputs 0.
- In INPUT, END_2 alone → LOSE. Separately, END_2 in the same cycle as a correct press → press accepted and START_2 re-pulses.
- R held 4 cycles with B=2 → exactly one press counted. A press during SHOW has no effect on idx.
- POWER mid-SHOW → IDLE next edge. Async RESET mid-INPUT (between clock edges) → outputs 0 immediately, with no clock edge required.
